mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the single-cycle RV32I core's data-memory bus, beside dmem.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART: register offsets, STATUS bit positions, TX FSM states.
package uart_pkg;

  localparam logic [3:0] TXDATA_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] DIVISOR_OFS = 4'h8;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_PARITY  = 4;
  localparam int unsigned STATUS_W   = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push while full is accepted only when a pop frees the slot in the same cycle.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (TXDATA / STATUS / DIVISOR) with TX FIFO and baud FSM.
// Optional even-parity bit enabled by defining UART_PARITY_EN (default build: 8N1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
  localparam logic [2:0] S_PARITY = 3'(PARITY);
  localparam logic [2:0] S_STOP   = 3'(STOP);

`ifdef UART_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_period;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_data;
  logic        r_tx;
  logic [15:0] r_div;
  logic        r_ovf;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_tx_nxt;
  logic        w_pop;
  logic        w_hit;
  logic [3:0]  w_ofs;
  logic        w_wr_tx;
  logic        w_wr_status;
  logic        w_wr_div;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_fifo_dout;
  logic        w_busy;
  logic [STATUS_W-1:0] w_status;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^wdata[31:16];

  // Window decode on addr[31:4]; register select on addr[3:0].
  assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs       = addr[3:0];
  assign w_wr_tx     = we & w_hit & (w_ofs == TXDATA_OFS);
  assign w_wr_status = we & w_hit & (w_ofs == STATUS_OFS);
  assign w_wr_div    = we & w_hit & (w_ofs == DIVISOR_OFS);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_fifo_dout)
  );

  assign w_busy  = (r_state != S_IDLE) | ~w_empty;
  assign tx_busy = w_busy;
  assign tx      = r_tx;

  // STATUS word assembly.
  always_comb begin
    w_status            = '0;
    w_status[ST_FULL]   = w_full;
    w_status[ST_EMPTY]  = w_empty;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_PARITY] = PARITY_PRESENT;
  end

  // Combinational read mux; misses and unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (w_ofs)
        STATUS_OFS:  rdata = 32'(w_status);
        DIVISOR_OFS: rdata = {16'h0000, r_div};
        default:     rdata = '0;
      endcase
    end
  end

  // DIVISOR and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      if (w_wr_tx && w_full && !w_pop)             r_ovf <= 1'b1;
      else if (w_wr_status && wdata[ST_OVF])       r_ovf <= 1'b0;
    end
  end

  // Next-state logic; tx is registered from the current state so it trails the FSM by one clock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_bit_idx;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_cnt_nxt   = r_div - 16'd1;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = r_period - 16'd1;
          w_idx_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_data[r_bit_idx];
        if (r_cnt == 16'd0) begin
          w_cnt_nxt = r_period - 16'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        w_tx_nxt = ^r_data;
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = r_period - 16'd1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (r_cnt == 16'd0) begin
          // Chain straight into the next START when more data is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_cnt_nxt   = r_div - 16'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // FSM, baud counter, frame data and serial output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_period  <= DEFAULT_DIV;
      r_bit_idx <= 3'd0;
      r_data    <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      if (w_pop) begin
        r_data   <= w_fifo_dout;
        r_period <= r_div;
      end
    end
  end

endmodule
